// File: rtl/uart_ahb_master.sv
// UART-driven AHB-Lite single-word initiator: 8N1 command frames in on rx,
// one bus transfer per frame, status or read data returned on tx.
`timescale 1ns/1ps
module uart_ahb_master #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int CLKS_PER_BIT = 8,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              rx,
  output logic              tx,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic [DWIDTH-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i,
  output logic              busy_o
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [7:0]  CMD_WR    = 8'h57;
  localparam logic [7:0]  CMD_RD    = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h45;
  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_AHB_ADDR, S_AHB_DATA, S_SEND_RESP
  } state_t;

  state_t              state_r, state_nx_s;
  logic                rx_meta_r, rx_sync_r, rx_prev_r, rx_busy_r, rx_valid_r;
  logic [3:0]          rx_bit_r;
  logic [15:0]         rx_cnt_r, tx_cnt_r;
  logic [7:0]          rx_shift_r, rx_byte_r, tx_byte_s;
  logic [9:0]          tx_shift_r;
  logic [3:0]          tx_left_r;
  logic                tx_idle_s, tx_load_s;
  logic                is_write_r, resp_err_r;
  logic [1:0]          byte_cnt_r;
  logic [2:0]          resp_left_r;
  logic [31:0]         addr_sh_r, addr_nx_s, tmo_r;
  logic [DWIDTH-1:0]   data_sh_r, data_nx_s, resp_data_r;
  logic [1:0]          htrans_r;
  logic [AWIDTH-1:0]   haddr_r;
  logic                hwrite_r, busy_r;
  logic [DWIDTH-1:0]   hwdata_r;

  assign tx_idle_s = (tx_left_r == 4'd0);
  assign tx        = tx_shift_r[0];
  assign htrans_o  = htrans_r;
  assign haddr_o   = haddr_r;
  assign hwrite_o  = hwrite_r;
  assign hwdata_o  = hwdata_r;
  assign busy_o    = busy_r;
  assign hsize_o   = 3'b010;
  assign hburst_o  = 3'b000;

  // Receiver: synchronize rx, sample mid start bit, then every bit centre.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_busy_r  <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_bit_r   <= 4'd0;
      rx_cnt_r   <= 16'd0;
      rx_shift_r <= 8'h00;
      rx_byte_r  <= 8'h00;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_valid_r <= 1'b0;
      if (!rx_busy_r) begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_busy_r <= 1'b1;
          rx_bit_r  <= 4'd0;
          rx_cnt_r  <= 16'd0;
        end
      end else if (rx_cnt_r == ((rx_bit_r == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        rx_cnt_r <= 16'd0;
        rx_bit_r <= rx_bit_r + 4'd1;
        if (rx_bit_r == 4'd0) begin
          if (rx_sync_r) rx_busy_r <= 1'b0;
        end else if (rx_bit_r == 4'd9) begin
          rx_busy_r <= 1'b0;
          if (rx_sync_r) begin
            rx_valid_r <= 1'b1;
            rx_byte_r  <= rx_shift_r;
          end
        end else begin
          rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
        end
      end else begin
        rx_cnt_r <= rx_cnt_r + 16'd1;
      end
    end
  end

  // Transmitter: 10-bit frame shifted out LSB first; shifts in ones so idle is high.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tx_shift_r <= 10'h3FF;
      tx_cnt_r   <= 16'd0;
      tx_left_r  <= 4'd0;
    end else if (tx_load_s) begin
      tx_shift_r <= {1'b1, tx_byte_s, 1'b0};
      tx_cnt_r   <= 16'd0;
      tx_left_r  <= 4'd10;
    end else if (!tx_idle_s) begin
      if (tx_cnt_r == BIT_LAST) begin
        tx_cnt_r   <= 16'd0;
        tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        tx_left_r  <= tx_left_r - 4'd1;
      end else begin
        tx_cnt_r <= tx_cnt_r + 16'd1;
      end
    end
  end

  // Next-state, response byte selection and field shift values.
  always_comb begin
    state_nx_s = state_r;
    tx_load_s  = 1'b0;
    addr_nx_s  = addr_sh_r;
    data_nx_s  = data_sh_r;
    if (resp_err_r) begin
      tx_byte_s = RSP_ERR;
    end else if (is_write_r) begin
      tx_byte_s = RSP_OK;
    end else begin
      tx_byte_s = resp_data_r[DWIDTH-1 -: 8];
    end
    case (state_r)
      S_IDLE: begin
        if (rx_valid_r && (rx_byte_r == CMD_WR || rx_byte_r == CMD_RD)) state_nx_s = S_GET_ADDR;
        else state_nx_s = S_IDLE;
      end
      S_GET_ADDR: begin
        if (rx_valid_r) begin
          addr_nx_s = {addr_sh_r[23:0], rx_byte_r};
          if (byte_cnt_r == 2'd3) state_nx_s = is_write_r ? S_GET_DATA : S_AHB_ADDR;
          else state_nx_s = S_GET_ADDR;
        end else if (tmo_r == TMO_LAST) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_GET_ADDR;
        end
      end
      S_GET_DATA: begin
        if (rx_valid_r) begin
          data_nx_s = {data_sh_r[DWIDTH-9:0], rx_byte_r};
          if (byte_cnt_r == 2'd3) state_nx_s = S_AHB_ADDR;
          else state_nx_s = S_GET_DATA;
        end else if (tmo_r == TMO_LAST) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_GET_DATA;
        end
      end
      S_AHB_ADDR: state_nx_s = hready_i ? S_AHB_DATA : S_AHB_ADDR;
      S_AHB_DATA: state_nx_s = hready_i ? S_SEND_RESP : S_AHB_DATA;
      S_SEND_RESP: begin
        if (resp_left_r != 3'd0) begin
          tx_load_s = tx_idle_s;
        end else if (tx_idle_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_SEND_RESP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Control state, frame fields, timeout and response capture.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= S_IDLE;
      is_write_r  <= 1'b0;
      byte_cnt_r  <= 2'd0;
      addr_sh_r   <= 32'd0;
      data_sh_r   <= '0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
      resp_left_r <= 3'd0;
      tmo_r       <= 32'd0;
    end else begin
      state_r   <= state_nx_s;
      addr_sh_r <= addr_nx_s;
      data_sh_r <= data_nx_s;
      if ((state_r == S_GET_ADDR || state_r == S_GET_DATA) && !rx_valid_r) tmo_r <= tmo_r + 32'd1;
      else tmo_r <= 32'd0;
      case (state_r)
        S_IDLE: begin
          if (state_nx_s == S_GET_ADDR) begin
            is_write_r <= (rx_byte_r == CMD_WR);
            byte_cnt_r <= 2'd0;
          end
        end
        S_GET_ADDR, S_GET_DATA: begin
          if (rx_valid_r) byte_cnt_r <= byte_cnt_r + 2'd1;
        end
        S_AHB_DATA: begin
          if (hready_i) begin
            resp_data_r <= hrdata_i;
            resp_err_r  <= hresp_i;
            resp_left_r <= (hresp_i || is_write_r) ? 3'd1 : 3'd4;
          end
        end
        S_SEND_RESP: begin
          if (tx_load_s) begin
            resp_left_r <= resp_left_r - 3'd1;
            resp_data_r <= {resp_data_r[DWIDTH-9:0], 8'h00};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus outputs registered from the next state so they align with it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      htrans_r <= TR_IDLE;
      haddr_r  <= '0;
      hwrite_r <= 1'b0;
      hwdata_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      busy_r   <= (state_nx_s != S_IDLE);
      htrans_r <= (state_nx_s == S_AHB_ADDR) ? TR_NONSEQ : TR_IDLE;
      if (state_r != S_AHB_ADDR && state_nx_s == S_AHB_ADDR) begin
        haddr_r  <= {addr_nx_s[AWIDTH-1:2], 2'b00};
        hwrite_r <= is_write_r;
        hwdata_r <= data_nx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_ahb_master.sv
// Bench for uart_ahb_master: UART host driver, AHB slave model, tx decoder
// and scoreboards for expected bus transfers and response bytes.
`timescale 1ns/1ps
module tb_uart_ahb_master;

  localparam int BIT_NS = 80;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [31:0] haddr_o, hwdata_o, hrdata_i;
  logic [1:0]  htrans_o;
  logic        hwrite_o, hready_i, hresp_i, busy_o;
  logic [2:0]  hsize_o, hburst_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_addr_q[$];
  logic        exp_wr_q[$];
  logic [31:0] exp_wd_q[$];

  int          slv_aw = 0;
  int          slv_dw = 0;
  logic        slv_err = 1'b0;
  logic        slv_stall = 1'b0;
  logic [31:0] slv_rdata = 32'd0;

  uart_ahb_master dut (
    .hclk(hclk), .hresetn(hresetn), .rx(rx), .tx(tx),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i), .busy_o(busy_o)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge hclk);
      if (!busy_o && exp_tx_q.size() == 0 && exp_addr_q.size() == 0) done = 1'b1;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
    check_eq({tag, "_htrans"}, {30'd0, htrans_o}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic err);
    slv_aw = 0; slv_dw = 1; slv_err = err; slv_rdata = 32'hFFFF_FFFF;
    exp_addr_q.push_back({a[31:2], 2'b00});
    exp_wr_q.push_back(1'b1);
    exp_wd_q.push_back(d);
    exp_tx_q.push_back(err ? 8'h45 : 8'h4B);
    send_byte(8'h57, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
    wait_done("wr_done");
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic err,
                         input int aw, input int dw);
    slv_aw = aw; slv_dw = dw; slv_err = err; slv_rdata = rd;
    exp_addr_q.push_back({a[31:2], 2'b00});
    exp_wr_q.push_back(1'b0);
    exp_wd_q.push_back(32'd0);
    if (err) exp_tx_q.push_back(8'h45);
    else for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rd[i*8 +: 8]);
    send_byte(8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b1);
    wait_done("rd_done");
  endtask

  // AHB slave model; every NONSEQ must match the next expected transfer.
  initial begin : slave
    logic        have;
    logic        ew;
    logic [31:0] ea, ewd;
    hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'd0;
    forever begin
      @(negedge hclk);
      if (hresetn && htrans_o == 2'b10) begin
        if (slv_stall) begin
          hready_i = 1'b0;
          while (htrans_o == 2'b10) @(negedge hclk);
          hready_i = 1'b1;
        end else begin
          have = (exp_addr_q.size() != 0);
          check_eq("xfer_expected", {31'd0, have}, 32'd1);
          ea = 32'd0; ew = 1'b0; ewd = 32'd0;
          if (have) begin
            ea = exp_addr_q.pop_front();
            ew = exp_wr_q.pop_front();
            ewd = exp_wd_q.pop_front();
            check_eq("haddr", haddr_o, ea);
            check_eq("hwrite", {31'd0, hwrite_o}, {31'd0, ew});
          end
          for (int k = 0; k < slv_aw; k++) begin
            hready_i = 1'b0;
            @(negedge hclk);
            check_eq("haddr_hold", haddr_o, ea);
            check_eq("htrans_hold", {30'd0, htrans_o}, 32'd2);
          end
          hready_i = 1'b1;
          @(negedge hclk);
          check_eq("htrans_dphase", {30'd0, htrans_o}, 32'd0);
          for (int k = 0; k < slv_dw; k++) begin
            hready_i = 1'b0;
            @(negedge hclk);
          end
          if (slv_err) begin
            hready_i = 1'b0; hresp_i = 1'b1;
            @(negedge hclk);
          end
          if (have && ew) check_eq("hwdata", hwdata_o, ewd);
          hready_i = 1'b1; hresp_i = slv_err; hrdata_i = slv_rdata;
          @(negedge hclk);
          hresp_i = 1'b0; hrdata_i = 32'd0;
        end
      end
    end
  end

  // Decode tx frames at bit centres and score them against expected bytes.
  initial begin : tx_mon
    logic [7:0] b;
    logic       have;
    wait (hresetn === 1'b1);
    forever begin
      @(negedge tx);
      #(BIT_NS / 2 + 5);
      check_eq("tx_start", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = tx;
      end
      #(BIT_NS);
      check_eq("tx_stop", {31'd0, tx}, 32'd1);
      have = (exp_tx_q.size() != 0);
      check_eq("tx_expected", {31'd0, have}, 32'd1);
      if (have) check_eq("tx_byte", {24'd0, b}, {24'd0, exp_tx_q.pop_front()});
    end
  end

  initial begin : watchdog
    #800us;
    $display("FAIL watchdog: got no finish expected finish by 800us");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic seen;
    repeat (5) @(negedge hclk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_htrans", {30'd0, htrans_o}, 32'd0);
    check_eq("rst_haddr", haddr_o, 32'd0);
    check_eq("rst_hwrite", {31'd0, hwrite_o}, 32'd0);
    check_eq("rst_hwdata", hwdata_o, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("hsize", {29'd0, hsize_o}, 32'd2);
    check_eq("hburst", {29'd0, hburst_o}, 32'd0);
    hresetn = 1'b1;
    repeat (20) @(negedge hclk);

    do_write(32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h0000_2000, 32'h1234_5678, 1'b0, 2, 3);
    do_read(32'h0000_3000, 32'h5555_AAAA, 1'b1, 0, 0);
    check_eq("err_busy", {31'd0, busy_o}, 32'd0);

    send_byte(8'h33, 1'b1);
    #(20 * BIT_NS);
    check_eq("garbage_busy", {31'd0, busy_o}, 32'd0);
    do_read(32'h0000_400B, 32'hA5A5_0F0F, 1'b0, 0, 1);

    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    #(55 * BIT_NS);
    check_eq("tmo_early_busy", {31'd0, busy_o}, 32'd1);
    #(15 * BIT_NS);
    check_eq("tmo_busy", {31'd0, busy_o}, 32'd0);
    do_write(32'h0000_5000, 32'h0102_0304, 1'b0);
    do_write(32'h0000_6000, 32'hCAFE_F00D, 1'b1);

    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    #(30 * BIT_NS);
    check_eq("frm_busy", {31'd0, busy_o}, 32'd1);
    #(45 * BIT_NS);
    check_eq("frm_tmo_busy", {31'd0, busy_o}, 32'd0);

    slv_stall = 1'b1;
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h08, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge hclk);
      if (htrans_o == 2'b10) seen = 1'b1;
    end
    check_eq("stall_nonseq", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge hclk);
    hresetn = 1'b0;
    #1;
    check_eq("mid_rst_htrans", {30'd0, htrans_o}, 32'd0);
    check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("mid_rst_haddr", haddr_o, 32'd0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    slv_stall = 1'b0;
    repeat (5) @(negedge hclk);
    do_read(32'h0000_9000, 32'h0BAD_F00D, 1'b0, 1, 0);

    #(20 * BIT_NS);
    check_eq("end_tx_q", exp_tx_q.size(), 32'd0);
    check_eq("end_xfer_q", exp_addr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
